// File: rtl/bus_master_burst_pkg.sv
// Shared definitions for the burst bus master and its transmit queue.
package bus_master_burst_pkg;

  // Grant code that no master owns; the arbiter drives it when the bus is free.
  localparam int GRANT_IDLE = 0;

  // Common bus width defaults.
  localparam int DEFAULT_N_MASTERS = 2;
  localparam int DEFAULT_GRANT_W   = 3;
  localparam int DEFAULT_DATA_W    = 5;

  // Master sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// Pushes while full and pops while empty are ignored internally.
module sync_fifo
  import bus_master_burst_pkg::*;
#(
  parameter int DATA_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [cnt_width(DEPTH)-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = cnt_width(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count_q == LVL_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Next storage, pointer and count values; pointers wrap naturally at DEPTH.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // FIFO state registers; reset discards all queued words.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/bus_master_burst.sv
// Shared-bus master: queues local words, requests the bus on a daisy-chained
// request vector and sends bounded bursts while granted, backing off after a
// full burst so other masters get a turn.
module bus_master_burst
  import bus_master_burst_pkg::*;
#(
  parameter int ID        = 1,
  parameter int N_MASTERS = DEFAULT_N_MASTERS,
  parameter int GRANT_W   = DEFAULT_GRANT_W,
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int DEPTH     = 4,
  parameter int BURST_MAX = 3,
  parameter int HOLDOFF   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [GRANT_W-1:0]       grant,
  input  logic [N_MASTERS-1:0]     in_request,
  output logic [N_MASTERS-1:0]     out_request,
  output logic [DATA_W-1:0]        data,
  output logic                     data_valid,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     burst_done
);

  localparam int LVL_W   = $clog2(DEPTH) + 1;
  localparam int BURST_W = cnt_width(BURST_MAX);
  localparam int HOLD_W  = cnt_width(HOLDOFF);

  state_e               state_q, state_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [BURST_W-1:0]   burst_next;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 data_valid_q, data_valid_d;
  logic                 burst_done_q, burst_done_d;
  logic                 overflow_q, overflow_d;

  logic [DATA_W-1:0]    fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [LVL_W-1:0]     fifo_level;
  logic                 fifo_pop;
  logic                 granted;
  logic                 push_ok;
  logic                 last_word;
  logic                 own_request;
  logic [N_MASTERS-1:0] own_vec;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (fifo_pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign granted   = (grant != GRANT_W'(GRANT_IDLE)) && (grant == GRANT_W'(ID));
  assign push_ok   = wr_en && !fifo_full;
  assign last_word = (fifo_level == LVL_W'(1)) && !push_ok;

  assign full       = fifo_full;
  assign empty      = fifo_empty;
  assign level      = fifo_level;
  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign overflow   = overflow_q;
  assign burst_done = burst_done_q;

  // State register plus the registered bus outputs and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      burst_cnt_q  <= '0;
      hold_cnt_q   <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      burst_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      burst_done_q <= burst_done_d;
      overflow_q   <= overflow_d;
    end
  end

  // Next state, tenure/hold-off counting and end-of-tenure detection.
  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    burst_done_d = 1'b0;
    overflow_d   = overflow_q | (wr_en && fifo_full);
    burst_next   = (state_q == ST_XFER) ? burst_cnt_q + 1'b1 : BURST_W'(1);
    unique case (state_q)
      ST_IDLE: begin
        burst_cnt_d = '0;
        if (!fifo_empty || push_ok) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ, ST_XFER: begin
        if (fifo_pop) begin
          burst_cnt_d = burst_next;
          state_d     = ST_XFER;
          if (burst_next == BURST_W'(BURST_MAX)) begin
            burst_done_d = 1'b1;
            burst_cnt_d  = '0;
            hold_cnt_d   = '0;
            if (HOLDOFF > 0) begin
              state_d = ST_HOLD;
            end else if (last_word) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_REQ;
            end
          end else if (last_word) begin
            burst_done_d = 1'b1;
            burst_cnt_d  = '0;
            state_d      = ST_IDLE;
          end
        end else begin
          // Lost the grant (or never had it): keep asking, restart the count.
          burst_cnt_d = '0;
          state_d     = fifo_empty ? ST_IDLE : ST_REQ;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_W'(HOLDOFF - 1)) begin
          hold_cnt_d = '0;
          state_d    = fifo_empty ? ST_IDLE : ST_REQ;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request chaining, pop decision and the next bus word (zero when idle).
  always_comb begin
    own_request      = (state_q == ST_REQ) || (state_q == ST_XFER);
    fifo_pop         = own_request && granted && !fifo_empty;
    own_vec          = '0;
    own_vec[ID-1]    = own_request;
    out_request      = in_request | own_vec;
    data_d           = fifo_pop ? fifo_dout : '0;
    data_valid_d     = fifo_pop;
  end

endmodule
